time_uart_reporter: RTL and testbench

- Transmit side of the time path. The watch and stopwatch datapaths count time and produce a packed 24-bit value; this block reads one snapshot of that value on request.
- It formats the snapshot as a 13-character ASCII line "HH:MM:SS.CC\r\n" and sends it out a UART TX pin (8N1, LSB first).
- It sits after the watch/stopwatch mux, in parallel with fnd_controller. It is triggered by a debounced button pulse or a periodic tick.

---
 rtl/time_uart_reporter_pkg.sv | 52 +++++
 rtl/time_uart_reporter_uart_tx.sv | 101 ++++++++++
 rtl/time_uart_reporter.sv | 114 +++++++++++
 tb/tb_time_uart_reporter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/time_uart_reporter_pkg.sv
// Shared definitions for the time path: packed time field positions, ASCII
// constants of the report line and the digit split used to format fields.
package time_uart_reporter_pkg;

   localparam int TIME_W   = 24;
   localparam int HOUR_MSB = 23;
   localparam int HOUR_LSB = 19;
   localparam int MIN_MSB  = 18;
   localparam int MIN_LSB  = 13;
   localparam int SEC_MSB  = 12;
   localparam int SEC_LSB  = 7;
   localparam int MSEC_MSB = 6;
   localparam int MSEC_LSB = 0;

   localparam logic [6:0] MSEC_MAX = 7'd99;

   localparam int LINE_LEN = 13;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_COLON = 8'h3A;
   localparam logic [7:0] ASCII_DOT   = 8'h2E;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
   } bcd2_t;

   // Compare ladder instead of a divider; callers keep v at 99 or below.
   function automatic bcd2_t split_digits(input logic [6:0] v);
      bcd2_t r;
      r.tens = 4'd0;
      for (int k = 1; k <= 9; k++) begin
         if (v >= 7'(k * 10)) r.tens = 4'(k);
      end
      r.ones = 4'(v - 7'(r.tens) * 7'd10);
      return r;
   endfunction

   function automatic logic [7:0] digit_char(input logic [3:0] d);
      return ASCII_ZERO + {4'h0, d};
   endfunction

endpackage

// File: rtl/time_uart_reporter_uart_tx.sv
// Byte-level 8N1 UART transmitter. A new byte may be accepted in the last
// cycle of a stop bit so that characters can be chained with no idle gap.
//
//   state    | meaning
//   TX_IDLE  | line high, waiting for i_start
//   TX_START | start bit (0) for BAUD_DIV cycles
//   TX_DATA  | data bits 0..7, BAUD_DIV cycles each, LSB first
//   TX_STOP  | stop bit (1); last cycle raises o_done and may accept i_start
module time_uart_reporter_uart_tx
   import time_uart_reporter_pkg::*;
#(
   parameter int BAUD_DIV = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_start,
   input  logic [7:0] i_data,
   output logic       o_tx,
   output logic       o_busy,
   output logic       o_done
);

   localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

   tx_state_e        state, state_next;
   logic [CNT_W-1:0] baud_cnt, baud_cnt_next;
   logic [2:0]       bit_idx, bit_idx_next;
   logic [7:0]       data, data_next;
   logic             bit_end;

   assign bit_end = (baud_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= TX_IDLE;
         baud_cnt <= '0;
         bit_idx  <= 3'd0;
         data     <= 8'h00;
      end else begin
         state    <= state_next;
         baud_cnt <= baud_cnt_next;
         bit_idx  <= bit_idx_next;
         data     <= data_next;
      end
   end

   always_comb begin
      state_next    = state;
      baud_cnt_next = bit_end ? '0 : baud_cnt + 1'b1;
      bit_idx_next  = bit_idx;
      data_next     = data;
      o_tx          = 1'b1;
      o_done        = 1'b0;

      case (state)
         TX_IDLE: begin
            baud_cnt_next = '0;
            if (i_start) begin
               state_next   = TX_START;
               data_next    = i_data;
               bit_idx_next = 3'd0;
            end
         end
         TX_START: begin
            o_tx = 1'b0;
            if (bit_end) begin
               state_next   = TX_DATA;
               bit_idx_next = 3'd0;
            end
         end
         TX_DATA: begin
            o_tx = data[bit_idx];
            if (bit_end) begin
               if (bit_idx == 3'd7) state_next = TX_STOP;
               else                 bit_idx_next = bit_idx + 3'd1;
            end
         end
         TX_STOP: begin
            o_tx = 1'b1;
            if (bit_end) begin
               o_done = 1'b1;
               if (i_start) begin
                  state_next   = TX_START;
                  data_next    = i_data;
                  bit_idx_next = 3'd0;
               end else begin
                  state_next = TX_IDLE;
               end
            end
         end
         default: begin
            state_next    = TX_IDLE;
            baud_cnt_next = '0;
         end
      endcase
   end

   assign o_busy = (state != TX_IDLE);

endmodule

// File: rtl/time_uart_reporter.sv
// Snapshots the packed time on request and sends it as "HH:MM:SS.CC\r\n"
// over UART, chaining the 13 characters back to back through one uart_tx.
module time_uart_reporter
   import time_uart_reporter_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 115200
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [TIME_W-1:0] i_time,
   input  logic              i_start,
   output logic              o_tx,
   output logic              o_busy,
   output logic              o_done
);

   localparam int BAUD_DIV = CLK_FREQ / BAUD;

   logic [TIME_W-1:0] snap;
   logic              active;
   logic [3:0]        char_idx;
   logic              done_q;

   logic              accept;
   logic              last_char;
   logic              byte_start;
   logic              byte_done;
   logic              byte_busy;
   logic [7:0]        byte_data;

   logic [TIME_W-1:0] src;
   logic [3:0]        sel_idx;
   logic [6:0]        msec_sat;
   bcd2_t             hour_d, min_d, sec_d, msec_d;

   assign accept    = i_start && !active && !byte_busy;
   assign last_char = (char_idx == 4'(LINE_LEN - 1));

   // The first character is formatted straight from i_time in the accept
   // cycle; later ones come from the snapshot, one index ahead of char_idx
   // because the next byte is loaded while the current stop bit ends.
   assign byte_start = accept || (active && byte_done && !last_char);
   assign src        = active ? snap : i_time;
   assign sel_idx    = active ? (char_idx + 4'd1) : 4'd0;

   assign msec_sat = (src[MSEC_MSB:MSEC_LSB] > MSEC_MAX) ? MSEC_MAX
                                                         : src[MSEC_MSB:MSEC_LSB];

   assign hour_d = split_digits({2'b00, src[HOUR_MSB:HOUR_LSB]});
   assign min_d  = split_digits({1'b0, src[MIN_MSB:MIN_LSB]});
   assign sec_d  = split_digits({1'b0, src[SEC_MSB:SEC_LSB]});
   assign msec_d = split_digits(msec_sat);

   always_comb begin
      byte_data = ASCII_LF;
      case (sel_idx)
         4'd0:    byte_data = digit_char(hour_d.tens);
         4'd1:    byte_data = digit_char(hour_d.ones);
         4'd2:    byte_data = ASCII_COLON;
         4'd3:    byte_data = digit_char(min_d.tens);
         4'd4:    byte_data = digit_char(min_d.ones);
         4'd5:    byte_data = ASCII_COLON;
         4'd6:    byte_data = digit_char(sec_d.tens);
         4'd7:    byte_data = digit_char(sec_d.ones);
         4'd8:    byte_data = ASCII_DOT;
         4'd9:    byte_data = digit_char(msec_d.tens);
         4'd10:   byte_data = digit_char(msec_d.ones);
         4'd11:   byte_data = ASCII_CR;
         4'd12:   byte_data = ASCII_LF;
         default: byte_data = ASCII_LF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         snap     <= '0;
         active   <= 1'b0;
         char_idx <= 4'd0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            snap     <= i_time;
            active   <= 1'b1;
            char_idx <= 4'd0;
         end else if (active && byte_done) begin
            if (last_char) begin
               active   <= 1'b0;
               char_idx <= 4'd0;
               done_q   <= 1'b1;
            end else begin
               char_idx <= char_idx + 4'd1;
            end
         end
      end
   end

   time_uart_reporter_uart_tx #(
      .BAUD_DIV (BAUD_DIV)
   ) u_uart_tx (
      .clk     (clk),
      .reset   (reset),
      .i_start (byte_start),
      .i_data  (byte_data),
      .o_tx    (o_tx),
      .o_busy  (byte_busy),
      .o_done  (byte_done)
   );

   assign o_busy = active;
   assign o_done = done_q;

endmodule

// File: tb/tb_time_uart_reporter.sv
// Directed bench for time_uart_reporter at BAUD_DIV=10 (1300-cycle lines).
module tb_time_uart_reporter;

   localparam int BD  = 10;
   localparam int CH  = 10 * BD;
   localparam int LOG = 2800;

   logic        clk;
   logic        reset;
   logic [23:0] i_time;
   logic        i_start;
   logic        o_tx;
   logic        o_busy;
   logic        o_done;

   int errors = 0;
   int checks = 0;

   logic tx_log   [0:LOG-1];
   logic busy_log [0:LOG-1];
   logic done_log [0:LOG-1];

   time_uart_reporter #(
      .CLK_FREQ (1000),
      .BAUD     (100)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .i_time  (i_time),
      .i_start (i_start),
      .o_tx    (o_tx),
      .o_busy  (o_busy),
      .o_done  (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at a negedge with the DUT idle; returns at the negedge of cycle 0
   // of start bit 0.
   task automatic send_start(input logic [23:0] t);
      i_time  = t;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   task automatic capture(input int ncyc, input int start_at, input int reset_at,
                          input bit scramble);
      for (int c = 0; c < ncyc; c++) begin
         tx_log[c]   = o_tx;
         busy_log[c] = o_busy;
         done_log[c] = o_done;
         i_start = (c == start_at);
         reset   = (c == reset_at);
         if (scramble) i_time = 24'($urandom);
         @(negedge clk);
      end
      i_start = 1'b0;
      reset   = 1'b0;
   endtask

   function automatic logic [7:0] decode_char(input int base, input int k);
      logic [7:0] d;
      for (int b = 0; b < 8; b++) d[b] = tx_log[base + k*CH + (b+1)*BD + BD/2];
      return d;
   endfunction

   function automatic int framing_errors(input int base);
      int n = 0;
      for (int k = 0; k < 13; k++) begin
         if (tx_log[base + k*CH] !== 1'b0) n++;
         if (tx_log[base + k*CH + BD/2] !== 1'b0) n++;
         if (tx_log[base + k*CH + 9*BD + BD/2] !== 1'b1) n++;
      end
      return n;
   endfunction

   function automatic logic [7:0] exp_char(input string s, input int k);
      if (k == 11) return 8'h0D;
      if (k == 12) return 8'h0A;
      return s[k];
   endfunction

   task automatic test_reset();
      reset = 1'b1; i_start = 1'b0; i_time = 24'h0;
      repeat (3) @(negedge clk);
      checks++; if (o_tx !== 1'b1)   begin errors++; $display("FAIL reset_tx got=%b exp=1", o_tx); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
      checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", o_done); end
      reset = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if (o_tx !== 1'b1 || o_busy !== 1'b0)
         begin errors++; $display("FAIL idle_hold got tx=%b busy=%b exp tx=1 busy=0", o_tx, o_busy); end
      reset = 1'b1; i_start = 1'b1; i_time = {5'd1, 6'd2, 6'd3, 7'd4};
      @(negedge clk);
      reset = 1'b0; i_start = 1'b0;
      checks++; if (o_busy !== 1'b0 || o_tx !== 1'b1)
         begin errors++; $display("FAIL reset_wins got tx=%b busy=%b exp tx=1 busy=0", o_tx, o_busy); end
      repeat (3) @(negedge clk);
      checks++; if (o_busy !== 1'b0)
         begin errors++; $display("FAIL reset_wins_late got busy=%b exp=0", o_busy); end
   endtask

   task automatic test_basic_line();
      string s = "12:34:56.78";
      int nb = 0, nd = 0, bad = 0;
      send_start({5'd12, 6'd34, 6'd56, 7'd78});
      capture(1310, -1, -1, 1'b0);
      for (int k = 0; k < 13; k++) begin
         checks++;
         if (decode_char(0, k) !== exp_char(s, k)) begin
            errors++; $display("FAIL basic_char%0d got=%h exp=%h", k, decode_char(0, k), exp_char(s, k));
         end
      end
      checks++; if (framing_errors(0) != 0)
         begin errors++; $display("FAIL basic_framing got=%0d bad bits exp=0", framing_errors(0)); end
      for (int c = 0; c < 1310; c++) begin
         if (c < 1300 && busy_log[c] === 1'b1) nb++;
         if (done_log[c] === 1'b1) nd++;
         if (c > 0 && c < 1300 && tx_log[c] !== tx_log[c-1] && (c % BD) != 0) bad++;
      end
      checks++; if (nb != 1300) begin errors++; $display("FAIL basic_busy_len got=%0d exp=1300", nb); end
      checks++; if (busy_log[1300] !== 1'b0) begin errors++; $display("FAIL basic_busy_end got=%b exp=0", busy_log[1300]); end
      checks++; if (done_log[1300] !== 1'b1) begin errors++; $display("FAIL basic_done_cycle got=%b exp=1", done_log[1300]); end
      checks++; if (nd != 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", nd); end
      checks++; if (bad != 0) begin errors++; $display("FAIL bit_timing got=%0d off-grid edges exp=0", bad); end
      checks++; if (tx_log[1300] !== 1'b1) begin errors++; $display("FAIL basic_tx_idle got=%b exp=1", tx_log[1300]); end
   endtask

   task automatic test_snapshot_sat();
      string s = "00:00:05.99";
      send_start({5'd0, 6'd0, 6'd5, 7'd120});
      capture(1310, -1, -1, 1'b1);
      for (int k = 0; k < 13; k++) begin
         checks++;
         if (decode_char(0, k) !== exp_char(s, k)) begin
            errors++; $display("FAIL snap_char%0d got=%h exp=%h", k, decode_char(0, k), exp_char(s, k));
         end
      end
      checks++; if (done_log[1300] !== 1'b1) begin errors++; $display("FAIL snap_done got=%b exp=1", done_log[1300]); end
   endtask

   task automatic test_busy_ignore();
      string s = "07:08:09.10";
      int nd = 0, late_busy = 0;
      send_start({5'd7, 6'd8, 6'd9, 7'd10});
      capture(1400, 400, -1, 1'b0);
      for (int k = 0; k < 13; k++) begin
         checks++;
         if (decode_char(0, k) !== exp_char(s, k)) begin
            errors++; $display("FAIL busy_char%0d got=%h exp=%h", k, decode_char(0, k), exp_char(s, k));
         end
      end
      for (int c = 0; c < 1400; c++) begin
         if (done_log[c] === 1'b1) nd++;
         if (c >= 1300 && busy_log[c] !== 1'b0) late_busy++;
      end
      checks++; if (nd != 1) begin errors++; $display("FAIL busy_done_count got=%0d exp=1", nd); end
      checks++; if (late_busy != 0) begin errors++; $display("FAIL busy_queued got=%0d busy cycles exp=0", late_busy); end
   endtask

   task automatic test_done_restart();
      string s = "31:63:63.00";
      int nd = 0;
      send_start({5'd31, 6'd63, 6'd63, 7'd0});
      capture(2610, 1300, -1, 1'b0);
      checks++; if (done_log[1300] !== 1'b1) begin errors++; $display("FAIL chain_done1 got=%b exp=1", done_log[1300]); end
      checks++; if (tx_log[1301] !== 1'b0 || busy_log[1301] !== 1'b1)
         begin errors++; $display("FAIL chain_restart got tx=%b busy=%b exp tx=0 busy=1", tx_log[1301], busy_log[1301]); end
      for (int k = 0; k < 13; k++) begin
         checks++;
         if (decode_char(0, k) !== exp_char(s, k) || decode_char(1301, k) !== exp_char(s, k)) begin
            errors++; $display("FAIL chain_char%0d got=%h/%h exp=%h", k, decode_char(0, k), decode_char(1301, k), exp_char(s, k));
         end
      end
      for (int c = 0; c < 2610; c++) if (done_log[c] === 1'b1) nd++;
      checks++; if (done_log[2601] !== 1'b1) begin errors++; $display("FAIL chain_done2 got=%b exp=1", done_log[2601]); end
      checks++; if (nd != 2) begin errors++; $display("FAIL chain_done_count got=%0d exp=2", nd); end
   endtask

   task automatic test_reset_midline();
      string s = "23:59:59.99";
      int nd = 0;
      send_start({5'd1, 6'd2, 6'd3, 7'd4});
      capture(600, -1, 537, 1'b0);
      checks++; if (tx_log[537] !== 1'b1 && busy_log[537] !== 1'b1)
         begin errors++; $display("FAIL abort_pre got busy=%b exp=1", busy_log[537]); end
      checks++; if (tx_log[538] !== 1'b1 || busy_log[538] !== 1'b0)
         begin errors++; $display("FAIL abort_idle got tx=%b busy=%b exp tx=1 busy=0", tx_log[538], busy_log[538]); end
      for (int c = 0; c < 600; c++) if (done_log[c] === 1'b1) nd++;
      checks++; if (nd != 0) begin errors++; $display("FAIL abort_done got=%0d pulses exp=0", nd); end
      send_start({5'd23, 6'd59, 6'd59, 7'd99});
      capture(1310, -1, -1, 1'b0);
      for (int k = 0; k < 13; k++) begin
         checks++;
         if (decode_char(0, k) !== exp_char(s, k)) begin
            errors++; $display("FAIL after_abort_char%0d got=%h exp=%h", k, decode_char(0, k), exp_char(s, k));
         end
      end
      checks++; if (framing_errors(0) != 0)
         begin errors++; $display("FAIL after_abort_framing got=%0d exp=0", framing_errors(0)); end
      checks++; if (done_log[1300] !== 1'b1) begin errors++; $display("FAIL after_abort_done got=%b exp=1", done_log[1300]); end
   endtask

   initial begin
      reset = 1'b1; i_start = 1'b0; i_time = 24'h0;
      @(negedge clk);
      test_reset();
      test_basic_line();
      test_snapshot_sat();
      test_busy_ignore();
      test_done_restart();
      test_reset_midline();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
